led_matrix_pixel_rx: RTL and testbench



---
 rtl/led_matrix_pixel_rx.sv | 75 +++++++
 tb/tb_led_matrix_pixel_rx.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_matrix_pixel_rx.sv
// led_matrix_pixel_rx: collects strobed pixel words into a write buffer, swaps it
// into a display buffer each frame, and scans the display buffer onto a 16x8 bicolour matrix.
module led_matrix_pixel_rx #(
  parameter int FRAME_SLOTS = 128,
  parameter int SCAN_DIV = 2000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [9:0] LEDIN,
  input  logic       STROBE,
  input  logic       FSYNC,
  output logic [3:0] ROWSEL,
  output logic [7:0] COLR,
  output logic [7:0] COLG,
  output logic       FRAME_DONE,
  output logic       SYNC_ERR
);
  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [7:0] LAST_SLOT = 8'(FRAME_SLOTS - 1);
  localparam logic [PW-1:0] LAST_TICK = PW'(SCAN_DIV - 1);
  logic [15:0][7:0] w_red, w_grn, d_red, d_grn, add_red, add_grn;
  logic [7:0] slot;
  logic [PW-1:0] tick;
  logic [3:0] row;
  logic swap_q;
  // One-hot image of the current word; all zero when not strobed or colour 00.
  always_comb begin
    add_red = '0;
    add_grn = '0;
    add_red[LEDIN[6:3]][LEDIN[2:0]] = STROBE & LEDIN[9];
    add_grn[LEDIN[6:3]][LEDIN[2:0]] = STROBE & LEDIN[8];
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      w_red <= '0;
      w_grn <= '0;
      d_red <= '0;
      d_grn <= '0;
      slot <= '0;
      tick <= '0;
      row <= '0;
      swap_q <= 1'b0;
      ROWSEL <= '0;
      COLR <= '0;
      COLG <= '0;
      FRAME_DONE <= 1'b0;
      SYNC_ERR <= 1'b0;
    end else begin
      swap_q <= STROBE && !FSYNC && slot == LAST_SLOT;
      FRAME_DONE <= swap_q;
      SYNC_ERR <= STROBE && FSYNC && slot != '0;
      if (STROBE && FSYNC) begin
        w_red <= add_red;
        w_grn <= add_grn;
        slot <= 8'd1;
      end else if (STROBE && slot == LAST_SLOT) begin
        d_red <= w_red | add_red;
        d_grn <= w_grn | add_grn;
        w_red <= '0;
        w_grn <= '0;
        slot <= '0;
      end else begin
        w_red <= w_red | add_red;
        w_grn <= w_grn | add_grn;
        slot <= slot + 8'(STROBE);
      end
      tick <= tick == LAST_TICK ? '0 : tick + 1'b1;
      row <= row + 4'(tick == LAST_TICK);
      ROWSEL <= row;
      // Blank the columns in the cycle the row select moves to avoid ghosting.
      COLR <= row != ROWSEL ? 8'h00 : d_red[row];
      COLG <= row != ROWSEL ? 8'h00 : d_grn[row];
    end
  end
endmodule

// File: tb/tb_led_matrix_pixel_rx.sv
// tb_led_matrix_pixel_rx: scoreboard bench; a reference model queues expected
// display frames at each swap and every cycle's outputs are compared against it.
module tb_led_matrix_pixel_rx;
  localparam int FS = 4;
  localparam int SD = 4;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic [9:0] LEDIN = '0;
  logic STROBE = 1'b0;
  logic FSYNC = 1'b0;
  logic [3:0] ROWSEL;
  logic [7:0] COLR, COLG;
  logic FRAME_DONE, SYNC_ERR;

  led_matrix_pixel_rx #(.FRAME_SLOTS(FS), .SCAN_DIV(SD)) dut (
    .CLK(CLK), .RST(RST), .LEDIN(LEDIN), .STROBE(STROBE), .FSYNC(FSYNC),
    .ROWSEL(ROWSEL), .COLR(COLR), .COLG(COLG), .FRAME_DONE(FRAME_DONE), .SYNC_ERR(SYNC_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0][7:0] r;
    logic [15:0][7:0] g;
    int due;
  } frame_t;
  frame_t q[$];
  logic [15:0][7:0] mw_r = '0, mw_g = '0, ed_r = '0, ed_g = '0;
  int mslot = 0, tick = 0, cyc = 0, fd_cnt = 0, se_cnt = 0, checks = 0, errors = 0;
  logic se_exp = 1'b0;

  always @(posedge CLK) begin
    cyc <= RST ? 0 : cyc + 1;
    if (FRAME_DONE) fd_cnt <= fd_cnt + 1;
    if (SYNC_ERR) se_cnt <= se_cnt + 1;
  end

  task automatic observe(input int n);
    logic efd;
    logic [3:0] er;
    logic [7:0] ecr, ecg;
    bit blank;
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      tick++;
      efd = q.size() > 0 && q[0].due == tick;
      if (efd) begin
        ed_r = q[0].r;
        ed_g = q[0].g;
        void'(q.pop_front());
      end
      er = cyc == 0 ? 4'd0 : 4'((cyc - 1) / SD);
      blank = cyc > 1 && (cyc - 1) % SD == 0;
      ecr = blank ? 8'h00 : ed_r[er];
      ecg = blank ? 8'h00 : ed_g[er];
      checks++;
      if ({ROWSEL, COLR, COLG, FRAME_DONE, SYNC_ERR} !== {er, ecr, ecg, efd, se_exp}) begin
        errors++;
        $display("FAIL scan t=%0d: got ROWSEL=%0d COLR=%h COLG=%h FD=%b SE=%b, expected %0d %h %h %b %b",
                 tick, ROWSEL, COLR, COLG, FRAME_DONE, SYNC_ERR, er, ecr, ecg, efd, se_exp);
      end
    end
  endtask

  task automatic send(input logic [9:0] w, input logic fs);
    logic [15:0][7:0] ar, ag;
    ar = '0;
    ag = '0;
    ar[w[6:3]][w[2:0]] = w[9];
    ag[w[6:3]][w[2:0]] = w[8];
    LEDIN = w;
    FSYNC = fs;
    STROBE = 1'b1;
    se_exp = fs && mslot != 0;
    if (fs) begin
      mw_r = ar;
      mw_g = ag;
      mslot = 1;
    end else if (mslot == FS - 1) begin
      q.push_back('{mw_r | ar, mw_g | ag, tick + 2});
      mw_r = '0;
      mw_g = '0;
      mslot = 0;
    end else begin
      mw_r |= ar;
      mw_g |= ag;
      mslot++;
    end
    observe(1);
    se_exp = 1'b0;
  endtask

  task automatic idle(input int n);
    STROBE = 1'b0;
    FSYNC = 1'b0;
    LEDIN = '0;
    observe(n);
  endtask

  task automatic do_reset();
    STROBE = 1'b0;
    FSYNC = 1'b0;
    RST = 1'b1;
    q.delete();
    mw_r = '0;
    mw_g = '0;
    ed_r = '0;
    ed_g = '0;
    mslot = 0;
    observe(2);
    RST = 1'b0;
  endtask

  // Leaves the bench in the second cycle of row r, where columns show D.
  task automatic wait_row(input logic [3:0] r);
    logic [3:0] prev;
    int n = 0;
    do begin
      prev = ROWSEL;
      idle(1);
      n++;
    end while (!(ROWSEL == r && prev != r) && n < 17 * SD + 2);
    checks++;
    if (ROWSEL !== r) begin
      errors++;
      $display("FAIL wait_row: ROWSEL=%0d never became %0d", ROWSEL, r);
    end
    idle(1);
  endtask

  task automatic test_reset();
    int f0, s0;
    do_reset();
    f0 = fd_cnt;
    s0 = se_cnt;
    idle(20);
    checks++;
    if (fd_cnt - f0 !== 0 || se_cnt - s0 !== 0) begin
      errors++;
      $display("FAIL reset_idle_pulses: fd=%0d se=%0d, expected 0 0", fd_cnt - f0, se_cnt - s0);
    end
  endtask

  task automatic test_single_frame();
    int f0 = fd_cnt;
    send(10'h268, 0);
    send(10'h11A, 0);
    send(10'h000, 0);
    send(10'h000, 0);
    idle(4);
    checks++;
    if (fd_cnt - f0 !== 1) begin
      errors++;
      $display("FAIL single_frame_done: pulses=%0d, expected 1", fd_cnt - f0);
    end
    wait_row(13);
    checks++;
    if (COLR !== 8'h01 || COLG !== 8'h00) begin
      errors++;
      $display("FAIL single_row13: COLR=%h COLG=%h, expected 01 00", COLR, COLG);
    end
    wait_row(3);
    checks++;
    if (COLR !== 8'h00 || COLG !== 8'h04) begin
      errors++;
      $display("FAIL single_row3: COLR=%h COLG=%h, expected 00 04", COLR, COLG);
    end
    wait_row(5);
    checks++;
    if (COLR !== 8'h00 || COLG !== 8'h00) begin
      errors++;
      $display("FAIL single_row5: COLR=%h COLG=%h, expected 00 00", COLR, COLG);
    end
  endtask

  task automatic test_or_accum();
    send(10'h205, 0);
    send(10'h105, 0);
    send(10'h000, 0);
    send(10'h000, 0);
    idle(4);
    wait_row(0);
    checks++;
    if (COLR !== 8'h20 || COLG !== 8'h20) begin
      errors++;
      $display("FAIL or_accum_row0: COLR=%h COLG=%h, expected 20 20", COLR, COLG);
    end
    for (int i = 0; i < FS; i++) send(10'h000, 0);
    idle(4);
    wait_row(0);
    checks++;
    if (COLR !== 8'h00 || COLG !== 8'h00) begin
      errors++;
      $display("FAIL or_clear_row0: COLR=%h COLG=%h, expected 00 00", COLR, COLG);
    end
  endtask

  task automatic test_resync();
    int f0 = fd_cnt;
    int s0 = se_cnt;
    send(10'h209, 0);
    send(10'h209, 0);
    send(10'h10F, 1);
    for (int i = 0; i < FS - 1; i++) send(10'h000, 0);
    idle(4);
    checks++;
    if (se_cnt - s0 !== 1 || fd_cnt - f0 !== 1) begin
      errors++;
      $display("FAIL resync_pulses: se=%0d fd=%0d, expected 1 1", se_cnt - s0, fd_cnt - f0);
    end
    wait_row(1);
    checks++;
    if (COLR !== 8'h00 || COLG !== 8'h80) begin
      errors++;
      $display("FAIL resync_row1: COLR=%h COLG=%h, expected 00 80", COLR, COLG);
    end
  endtask

  task automatic test_scan();
    logic [3:0] prev = ROWSEL;
    int last = -1, wraps = 0;
    for (int i = 0; i < 2 * 16 * SD + 2; i++) begin
      idle(1);
      if (ROWSEL != prev) begin
        checks++;
        if (ROWSEL !== 4'(prev + 1) || COLR !== 8'h00 || COLG !== 8'h00 || (last >= 0 && i - last != SD)) begin
          errors++;
          $display("FAIL scan_step: ROWSEL %0d->%0d period=%0d COLR=%h COLG=%h, expected +1 period %0d blank",
                   prev, ROWSEL, i - last, COLR, COLG, SD);
        end
        if (ROWSEL == 0) wraps++;
        last = i;
        prev = ROWSEL;
      end
    end
    checks++;
    if (wraps < 1) begin
      errors++;
      $display("FAIL scan_wrap: wraps=%0d, expected >=1", wraps);
    end
  endtask

  task automatic test_reset_mid();
    int f0, s0;
    send(10'h268, 0);
    send(10'h11A, 0);
    do_reset();
    f0 = fd_cnt;
    s0 = se_cnt;
    send(10'h3FF, 0);
    for (int i = 0; i < FS - 1; i++) send(10'h000, 0);
    idle(4);
    checks++;
    if (fd_cnt - f0 !== 1 || se_cnt - s0 !== 0) begin
      errors++;
      $display("FAIL reset_mid_pulses: fd=%0d se=%0d, expected 1 0", fd_cnt - f0, se_cnt - s0);
    end
    wait_row(15);
    checks++;
    if (COLR !== 8'h80 || COLG !== 8'h80) begin
      errors++;
      $display("FAIL reset_mid_row15: COLR=%h COLG=%h, expected 80 80", COLR, COLG);
    end
    wait_row(13);
    checks++;
    if (COLR !== 8'h00 || COLG !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid_row13: COLR=%h COLG=%h, expected 00 00", COLR, COLG);
    end
  endtask

  task automatic test_back_to_back();
    int f0 = fd_cnt;
    send(10'h214, 0);
    for (int i = 0; i < FS - 1; i++) send(10'h000, 0);
    send(10'h114, 0);
    for (int i = 0; i < FS - 1; i++) send(10'h000, 0);
    idle(4);
    checks++;
    if (fd_cnt - f0 !== 2) begin
      errors++;
      $display("FAIL b2b_frames: pulses=%0d, expected 2", fd_cnt - f0);
    end
    wait_row(2);
    checks++;
    if (COLR !== 8'h00 || COLG !== 8'h10) begin
      errors++;
      $display("FAIL b2b_row2: COLR=%h COLG=%h, expected 00 10", COLR, COLG);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_or_accum();
    test_resync();
    test_scan();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
